// File: rtl/fd_cmd_tx.sv
`default_nettype none
// ============================================================================
//  Module   : fd_cmd_tx
//  Purpose  : Initiator-side driver for the FD food-delivery input protocol.
//             Accepts one command per handshake, serialises its fields onto
//             the shared 48-bit DATA bus as one-cycle strobes separated by
//             idle gaps, waits for FD's out_valid and returns the result.
//  Option   : FD_TX_RAND_GAP_EN - gaps drawn from an 8-bit LFSR (1..5 cycles)
//             instead of the fixed GAP parameter.
//  Revision : 1.0 - initial release
// ============================================================================
module fd_cmd_tx #(
  parameter int         GAP       = 1,
  parameter int         TIMEOUT   = 1200,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_act,
  input  logic        cmd_id_en,
  input  logic [7:0]  cmd_dman_id,
  input  logic [15:0] cmd_ctm_info,
  input  logic        cmd_res_en,
  input  logic [7:0]  cmd_res_id,
  input  logic [5:0]  cmd_food,
  output logic        act_valid,
  output logic        id_valid,
  output logic        cus_valid,
  output logic        res_valid,
  output logic        food_valid,
  output logic [47:0] D,
  input  logic        out_valid,
  input  logic [3:0]  err_msg,
  input  logic        complete,
  input  logic [63:0] out_info,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_status,
  output logic [3:0]  rsp_err,
  output logic        rsp_complete,
  output logic [63:0] rsp_info
);

  localparam int                  c_WCNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(TIMEOUT - 1);

  localparam logic [2:0] c_S_IDLE = 3'd0;
  localparam logic [2:0] c_S_SEND = 3'd1;
  localparam logic [2:0] c_S_GAP  = 3'd2;
  localparam logic [2:0] c_S_WAIT = 3'd3;
  localparam logic [2:0] c_S_RESP = 3'd4;

  // Field kinds held in the per-command send sequence
  localparam logic [2:0] c_F_ACT  = 3'd0;
  localparam logic [2:0] c_F_ID   = 3'd1;
  localparam logic [2:0] c_F_CUS  = 3'd2;
  localparam logic [2:0] c_F_RES  = 3'd3;
  localparam logic [2:0] c_F_FOOD = 3'd4;

  localparam logic [1:0] c_RSP_OK      = 2'd0;
  localparam logic [1:0] c_RSP_TIMEOUT = 2'd1;
  localparam logic [1:0] c_RSP_ILLEGAL = 2'd2;

  logic [2:0]          r_state;
  logic [2:0]          w_next;
  logic [3:0]          r_act;
  logic [7:0]          r_id;
  logic [15:0]         r_cus;
  logic [7:0]          r_res;
  logic [5:0]          r_food;
  logic [3:0][2:0]     r_seq;
  logic [1:0]          r_last;
  logic [1:0]          r_idx;
  logic [2:0]          r_gap_cnt;
  logic [c_WCNT_W-1:0] r_wcnt;
  logic [1:0]          r_rsp_status;
  logic [3:0]          r_rsp_err;
  logic                r_rsp_complete;
  logic [63:0]         r_rsp_info;

  logic [3:0][2:0]     w_seq;
  logic [1:0]          w_last;
  logic                w_legal;
  logic                w_accept;
  logic [2:0]          w_gap_tgt;

  assign w_accept = cmd_valid && (r_state == c_S_IDLE);

`ifdef FD_TX_RAND_GAP_EN
  logic [7:0] r_lfsr;
  logic       w_lfsr_fb;
  logic [2:0] w_unused_gap;

  assign w_unused_gap = 3'(GAP);
  assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_gap_tgt    = (r_lfsr[2:0] % 3'd5) + 3'd1;

  // Gap LFSR: advances once per strobe so the following gap uses a fresh draw
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (r_state == c_S_SEND) begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end
  end
`else
  logic [7:0] w_unused_seed;

  assign w_unused_seed = LFSR_SEED;
  assign w_gap_tgt     = 3'(GAP);
`endif

  // Build the ordered list of fields to send for the offered action
  always_comb begin
    w_seq    = '0;
    w_last   = 2'd0;
    w_legal  = 1'b1;
    w_seq[0] = c_F_ACT;
    case (cmd_act)
      4'd1: begin
        if (cmd_id_en) begin
          w_seq[1] = c_F_ID;
          w_seq[2] = c_F_CUS;
          w_last   = 2'd2;
        end else begin
          w_seq[1] = c_F_CUS;
          w_last   = 2'd1;
        end
      end
      4'd2: begin
        w_seq[1] = c_F_ID;
        w_last   = 2'd1;
      end
      4'd4: begin
        if (cmd_res_en) begin
          w_seq[1] = c_F_RES;
          w_seq[2] = c_F_FOOD;
          w_last   = 2'd2;
        end else begin
          w_seq[1] = c_F_FOOD;
          w_last   = 2'd1;
        end
      end
      4'd8: begin
        w_seq[1] = c_F_RES;
        w_seq[2] = c_F_FOOD;
        w_seq[3] = c_F_ID;
        w_last   = 2'd3;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE: if (w_accept) w_next = w_legal ? c_S_SEND : c_S_RESP;
      c_S_SEND: w_next = (r_idx == r_last) ? c_S_WAIT : c_S_GAP;
      c_S_GAP:  if (r_gap_cnt == (w_gap_tgt - 3'd1)) w_next = c_S_SEND;
      c_S_WAIT: if (out_valid || (r_wcnt == c_WCNT_LAST)) w_next = c_S_RESP;
      c_S_RESP: if (rsp_ready) w_next = c_S_IDLE;
      default:  w_next = c_S_IDLE;
    endcase
  end

  // Command latch, sequencing counters and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_act          <= '0;
      r_id           <= '0;
      r_cus          <= '0;
      r_res          <= '0;
      r_food         <= '0;
      r_seq          <= '0;
      r_last         <= '0;
      r_idx          <= '0;
      r_gap_cnt      <= '0;
      r_wcnt         <= '0;
      r_rsp_status   <= '0;
      r_rsp_err      <= '0;
      r_rsp_complete <= 1'b0;
      r_rsp_info     <= '0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (w_accept) begin
            r_act  <= cmd_act;
            r_id   <= cmd_dman_id;
            r_cus  <= cmd_ctm_info;
            r_res  <= cmd_res_id;
            r_food <= cmd_food;
            r_seq  <= w_seq;
            r_last <= w_last;
            r_idx  <= 2'd0;
            if (!w_legal) r_rsp_status <= c_RSP_ILLEGAL;
          end
        end
        c_S_SEND: begin
          r_gap_cnt <= '0;
          r_wcnt    <= '0;
          if (r_idx != r_last) r_idx <= r_idx + 2'd1;
        end
        c_S_GAP: begin
          if (r_gap_cnt != w_gap_tgt) r_gap_cnt <= r_gap_cnt + 3'd1;
        end
        c_S_WAIT: begin
          // out_valid takes priority over a simultaneous timeout
          if (out_valid) begin
            r_rsp_status   <= c_RSP_OK;
            r_rsp_err      <= err_msg;
            r_rsp_complete <= complete;
            r_rsp_info     <= out_info;
          end else if (r_wcnt == c_WCNT_LAST) begin
            r_rsp_status   <= c_RSP_TIMEOUT;
            r_rsp_err      <= '0;
            r_rsp_complete <= 1'b0;
            r_rsp_info     <= '0;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        c_S_RESP: begin
          if (rsp_ready) begin
            r_rsp_status   <= '0;
            r_rsp_err      <= '0;
            r_rsp_complete <= 1'b0;
            r_rsp_info     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: one strobe plus its zero-extended field in SEND, otherwise quiet
  always_comb begin
    act_valid  = 1'b0;
    id_valid   = 1'b0;
    cus_valid  = 1'b0;
    res_valid  = 1'b0;
    food_valid = 1'b0;
    D          = '0;
    cmd_ready  = (r_state == c_S_IDLE) && !rst;
    rsp_valid  = (r_state == c_S_RESP);
    if (r_state == c_S_SEND) begin
      case (r_seq[r_idx])
        c_F_ACT:  begin act_valid  = 1'b1; D = {44'd0, r_act};  end
        c_F_ID:   begin id_valid   = 1'b1; D = {40'd0, r_id};   end
        c_F_CUS:  begin cus_valid  = 1'b1; D = {32'd0, r_cus};  end
        c_F_RES:  begin res_valid  = 1'b1; D = {40'd0, r_res};  end
        c_F_FOOD: begin food_valid = 1'b1; D = {42'd0, r_food}; end
        default:  ;
      endcase
    end
  end

  assign rsp_status   = r_rsp_status;
  assign rsp_err      = r_rsp_err;
  assign rsp_complete = r_rsp_complete;
  assign rsp_info     = r_rsp_info;

endmodule
`default_nettype wire

// File: tb/tb_fd_cmd_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fd_cmd_tx
//  Purpose  : Self-checking bench for fd_cmd_tx. Two instances (GAP=1 and
//             GAP=3, TIMEOUT=16) are exercised one at a time through a
//             select; a field-list model predicts strobes, D and responses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fd_cmd_tx;

  localparam int GAP_A = 1;
  localparam int GAP_B = 3;
  localparam int TO    = 16;

  localparam logic [4:0] S_ACT  = 5'b10000;
  localparam logic [4:0] S_ID   = 5'b01000;
  localparam logic [4:0] S_CUS  = 5'b00100;
  localparam logic [4:0] S_RES  = 5'b00010;
  localparam logic [4:0] S_FOOD = 5'b00001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [3:0]  cmd_act = '0;
  logic        cmd_id_en = 1'b0;
  logic [7:0]  cmd_dman_id = '0;
  logic [15:0] cmd_ctm_info = '0;
  logic        cmd_res_en = 1'b0;
  logic [7:0]  cmd_res_id = '0;
  logic [5:0]  cmd_food = '0;
  logic        out_valid = 1'b0;
  logic [3:0]  err_msg = '0;
  logic        complete = 1'b0;
  logic [63:0] out_info = '0;
  logic        rsp_ready = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wire a_cv = cmd_valid & ~sel;
  wire b_cv = cmd_valid & sel;
  wire a_ov = out_valid & ~sel;
  wire b_ov = out_valid & sel;
  wire a_rr = rsp_ready & ~sel;
  wire b_rr = rsp_ready & sel;

  wire [4:0]  a_strb, b_strb;
  wire [47:0] a_d, b_d;
  wire        a_rdy, b_rdy, a_rv, b_rv, a_cmp, b_cmp;
  wire [1:0]  a_st, b_st;
  wire [3:0]  a_err, b_err;
  wire [63:0] a_info, b_info;

  fd_cmd_tx #(.GAP(GAP_A), .TIMEOUT(TO), .LFSR_SEED(8'hA5)) u_a (
    .clk(clk), .rst(rst), .cmd_valid(a_cv), .cmd_ready(a_rdy),
    .cmd_act(cmd_act), .cmd_id_en(cmd_id_en), .cmd_dman_id(cmd_dman_id),
    .cmd_ctm_info(cmd_ctm_info), .cmd_res_en(cmd_res_en), .cmd_res_id(cmd_res_id),
    .cmd_food(cmd_food), .act_valid(a_strb[4]), .id_valid(a_strb[3]),
    .cus_valid(a_strb[2]), .res_valid(a_strb[1]), .food_valid(a_strb[0]),
    .D(a_d), .out_valid(a_ov), .err_msg(err_msg), .complete(complete),
    .out_info(out_info), .rsp_valid(a_rv), .rsp_ready(a_rr), .rsp_status(a_st),
    .rsp_err(a_err), .rsp_complete(a_cmp), .rsp_info(a_info)
  );

  fd_cmd_tx #(.GAP(GAP_B), .TIMEOUT(TO), .LFSR_SEED(8'hA5)) u_b (
    .clk(clk), .rst(rst), .cmd_valid(b_cv), .cmd_ready(b_rdy),
    .cmd_act(cmd_act), .cmd_id_en(cmd_id_en), .cmd_dman_id(cmd_dman_id),
    .cmd_ctm_info(cmd_ctm_info), .cmd_res_en(cmd_res_en), .cmd_res_id(cmd_res_id),
    .cmd_food(cmd_food), .act_valid(b_strb[4]), .id_valid(b_strb[3]),
    .cus_valid(b_strb[2]), .res_valid(b_strb[1]), .food_valid(b_strb[0]),
    .D(b_d), .out_valid(b_ov), .err_msg(err_msg), .complete(complete),
    .out_info(out_info), .rsp_valid(b_rv), .rsp_ready(b_rr), .rsp_status(b_st),
    .rsp_err(b_err), .rsp_complete(b_cmp), .rsp_info(b_info)
  );

  wire [4:0]  strb    = sel ? b_strb : a_strb;
  wire [47:0] dbus    = sel ? b_d    : a_d;
  wire        o_rdy   = sel ? b_rdy  : a_rdy;
  wire        o_rv    = sel ? b_rv   : a_rv;
  wire [1:0]  o_st    = sel ? b_st   : a_st;
  wire [3:0]  o_err   = sel ? b_err  : a_err;
  wire        o_cmp   = sel ? b_cmp  : a_cmp;
  wire [63:0] o_info  = sel ? b_info : a_info;

  task automatic chk(input string name, input string tag,
                     input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", name, tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string name, input logic exp_rdy);
    chk(name, "strobes", 64'(strb), 64'd0);
    chk(name, "D", 64'(dbus), 64'd0);
    chk(name, "cmd_ready", 64'(o_rdy), 64'(exp_rdy));
    chk(name, "rsp_valid", 64'(o_rv), 64'd0);
    chk(name, "rsp_status", 64'(o_st), 64'd0);
    chk(name, "rsp_err", 64'(o_err), 64'd0);
    chk(name, "rsp_complete", 64'(o_cmp), 64'd0);
    chk(name, "rsp_info", o_info, 64'd0);
  endtask

  // ov_dly: cycles after the last strobe at which out_valid is pulsed (0 = never)
  // hold:   cycles rsp_ready stays low while the response is offered
  task automatic run_cmd(input logic s, input logic [3:0] act, input logic id_en,
                         input logic [7:0] id, input logic [15:0] cus,
                         input logic res_en, input logic [7:0] res, input logic [5:0] food,
                         input int ov_dly, input logic [3:0] ov_err, input logic ov_cmp,
                         input logic [63:0] ov_info, input int hold, input string name);
    logic [4:0]  es[$];
    logic [47:0] ed[$];
    int          g, L, R, k, idx;
    logic        legal;
    logic [1:0]  x_st;
    logic [3:0]  x_err;
    logic        x_cmp;
    logic [63:0] x_info;
    logic [4:0]  e_s;
    logic [47:0] e_d;

    sel   = s;
    g     = s ? GAP_B : GAP_A;
    legal = 1'b1;
    es.push_back(S_ACT); ed.push_back({44'd0, act});
    case (act)
      4'd1: begin
        if (id_en) begin es.push_back(S_ID); ed.push_back({40'd0, id}); end
        es.push_back(S_CUS); ed.push_back({32'd0, cus});
      end
      4'd2: begin es.push_back(S_ID); ed.push_back({40'd0, id}); end
      4'd4: begin
        if (res_en) begin es.push_back(S_RES); ed.push_back({40'd0, res}); end
        es.push_back(S_FOOD); ed.push_back({42'd0, food});
      end
      4'd8: begin
        es.push_back(S_RES);  ed.push_back({40'd0, res});
        es.push_back(S_FOOD); ed.push_back({42'd0, food});
        es.push_back(S_ID);   ed.push_back({40'd0, id});
      end
      default: legal = 1'b0;
    endcase

    x_st = 2'd0; x_err = '0; x_cmp = 1'b0; x_info = '0;
    if (!legal) begin
      L = 0; R = 1; x_st = 2'd2;
    end else begin
      L = 1 + (es.size() - 1) * (g + 1);
      if (ov_dly > 0 && ov_dly <= TO) begin
        R = L + ov_dly + 1; x_err = ov_err; x_cmp = ov_cmp; x_info = ov_info;
      end else begin
        R = L + TO + 1; x_st = 2'd1;
      end
    end

    k = 0;
    while (o_rdy !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    chk(name, "cmd_ready_before", 64'(o_rdy), 64'd1);

    cmd_act = act; cmd_id_en = id_en; cmd_dman_id = id; cmd_ctm_info = cus;
    cmd_res_en = res_en; cmd_res_id = res; cmd_food = food;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    out_valid = 1'b0;

    for (int c = 1; c <= R + hold; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      e_s = '0; e_d = '0;
      if (legal && c <= L && ((c - 1) % (g + 1)) == 0) begin
        idx = (c - 1) / (g + 1);
        e_s = es[idx]; e_d = ed[idx];
      end
      chk(name, "strobes", 64'(strb), 64'(e_s));
      chk(name, "D", 64'(dbus), 64'(e_d));
      chk(name, "cmd_ready_busy", 64'(o_rdy), 64'd0);
      if (c < R) begin
        chk(name, "rsp_valid_early", 64'(o_rv), 64'd0);
      end else begin
        chk(name, "rsp_valid", 64'(o_rv), 64'd1);
        chk(name, "rsp_status", 64'(o_st), 64'(x_st));
        chk(name, "rsp_err", 64'(o_err), 64'(x_err));
        chk(name, "rsp_complete", 64'(o_cmp), 64'(x_cmp));
        chk(name, "rsp_info", o_info, x_info);
      end
      rsp_ready = (c == R + hold);
      if (legal && x_st == 2'd0 && c == L + ov_dly) begin
        out_valid = 1'b1; err_msg = x_err; complete = x_cmp; out_info = x_info;
      end else if (c == 2) begin
        out_valid = 1'b1; err_msg = 4'($urandom_range(1, 15)); complete = 1'b1;
        out_info = {$urandom, $urandom} | 64'h1;
      end else begin
        out_valid = 1'b0;
      end
    end

    @(negedge clk);
    chk_idle_outputs({name, "_after"}, 1'b1);
    rsp_ready = 1'b0;
    out_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] ract;
    int         r;

    // Reset behaviour
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("post_reset", 1'b1);

    // Directed cases
    run_cmd(0, 4'd1, 1, 8'h05, 16'hC423, 0, 8'h00, 6'h00, 4, 4'h3, 1, 64'h1234, 0, "take_gap1");
    run_cmd(0, 4'd4, 0, 8'h00, 16'h0000, 0, 8'h99, 6'h12, 2, 4'h0, 1, 64'hABCD, 1, "order_nores");
    run_cmd(1, 4'd8, 0, 8'h07, 16'h0000, 0, 8'h22, 6'h31, 5, 4'h1, 0, 64'h55, 0, "cancel_gap3");
    run_cmd(0, 4'd2, 0, 8'h11, 16'h0000, 0, 8'h00, 6'h00, 6, 4'hA, 0, 64'h0, 3, "deliver_hold3");
    run_cmd(0, 4'd2, 0, 8'h3C, 16'h0000, 0, 8'h00, 6'h00, 0, 4'h0, 0, 64'h0, 1, "timeout");
    run_cmd(1, 4'd4, 0, 8'h00, 16'h0000, 1, 8'h5A, 6'h2B, TO, 4'h6, 1, 64'hFEED_0000_BEEF, 0, "ov_tie_timeout");
    run_cmd(0, 4'd3, 1, 8'hFF, 16'hFFFF, 1, 8'hFF, 6'h3F, 3, 4'h0, 0, 64'h0, 2, "illegal_act");
    run_cmd(1, 4'd0, 0, 8'h00, 16'h0000, 0, 8'h00, 6'h00, 0, 4'h0, 0, 64'h0, 0, "illegal_zero");

    // Reset asserted mid-gap of a Cancel
    sel = 1'b1;
    cmd_act = 4'd8; cmd_res_id = 8'h22; cmd_food = 6'h31; cmd_dman_id = 8'h07;
    chk("rst_gap", "cmd_ready_before", 64'(o_rdy), 64'd1);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_gap", "act_strobe", 64'(strb), 64'(S_ACT));
    chk("rst_gap", "act_D", 64'(dbus), 64'd8);
    @(negedge clk);
    chk("rst_gap", "gap_strobes", 64'(strb), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("rst_gap_in_reset", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("rst_gap_released", 1'b1);
    run_cmd(1, 4'd1, 1, 8'h05, 16'hC423, 0, 8'h00, 6'h00, 3, 4'h2, 1, 64'h77, 0, "take_after_rst");

    // Randomised commands on both instances
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 8);
      case (r)
        0, 1: ract = 4'd1;
        2, 3: ract = 4'd2;
        4, 5: ract = 4'd4;
        6, 7: ract = 4'd8;
        default: begin
          ract = 4'($urandom_range(0, 15));
          if (ract == 4'd1 || ract == 4'd2 || ract == 4'd4 || ract == 4'd8) ract = 4'd6;
        end
      endcase
      run_cmd(1'($urandom_range(0, 1)), ract, 1'($urandom), 8'($urandom), 16'($urandom),
              1'($urandom), 8'($urandom), 6'($urandom), $urandom_range(0, TO),
              4'($urandom), 1'($urandom), {$urandom, $urandom}, $urandom_range(0, 3),
              "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fd_cmd_tx.md
Name: fd_cmd_tx

Overview:
- Initiator-side driver for the FD food-delivery input protocol.
- Accepts one complete command per handshake: action, delivery-man ID, customer info, restaurant ID, food ID/servings.
- Serialises the command onto the shared 48-bit DATA bus as one-cycle valid pulses with inter-field gaps, then waits for FD's single-cycle out_valid.
- Captures err_msg/complete/out_info and returns them as a response. Used by the pattern/bench environment and by the system-level traffic generator.

Parameters:
GAP, 1, idle cycles between consecutive field pulses (legal 1..5).
TIMEOUT, 1200, max cycles in WAIT_OUT after the last field before timeout.
LFSR_SEED, 8'hA5, reset seed of gap LFSR (used only with optional feature).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_act  in  4  Action encoding (1 Take, 2 Deliver, 4 Order, 8 Cancel)
cmd_id_en  in  1  Take only: send delivery-man ID field
cmd_dman_id  in  8  delivery-man ID
cmd_ctm_info  in  16  Ctm_Info {status[15:14], res_ID[13:6], food_ID[5:4], ser[3:0]}
cmd_res_en  in  1  Order only: send restaurant ID field
cmd_res_id  in  8  restaurant ID
cmd_food  in  6  food_ID_servings {food_ID[5:4], ser[3:0]}
act_valid, id_valid, cus_valid, res_valid, food_valid  out  1 each  field strobes to FD
D  out  48  DATA bus
out_valid  in  1  FD response strobe
err_msg  in  4  FD Error_Msg
complete  in  1  FD complete flag
out_info  in  64  FD OUT_INFO {D_man_Info[63:32], res_info[31:0]}
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_status  out  2  0 OK, 1 timeout, 2 illegal command
rsp_err  out  4  captured err_msg
rsp_complete  out  1  captured complete
rsp_info  out  64  captured out_info

Behaviour:
- Reset values: all outputs 0, except cmd_ready, which is 0 during reset and 1 in IDLE on the first cycle after rst deasserts.
- Reset is synchronous. Asserting rst in any state returns the FSM to IDLE and clears strobes, D and the response on the same edge. No partial command is resumed.
- FSM states: IDLE, SEND, GAP, WAIT_OUT, RESP.
- Acceptance: cmd_valid && cmd_ready at edge T latches all cmd_* fields.
  - cmd_act not in {1,2,4,8}: go to RESP with rsp_status=2. rsp_valid=1 from T+1. No strobes are sent.
- Field sequence, after act, by action:
  - Take: id (only if cmd_id_en), cus.
  - Deliver: id.
  - Order: res (only if cmd_res_en), food.
  - Cancel: res, food, id.
- Strobe timing:
  - act_valid is high in cycle T+1.
  - Each following strobe comes exactly GAP+1 cycles after the previous one, with GAP idle cycles in between.
  - Exactly one strobe is high in any cycle; each strobe is one cycle wide.
- D contents:
  - D carries the field zero-extended: act in [3:0], id/res in [7:0], cus in [15:0], food in [5:0].
  - D is 0 whenever no strobe is high.
- WAIT_OUT: entered the cycle after the last strobe. The wait counter starts at 0 and increments each cycle.
  - out_valid seen: latch err_msg/complete/out_info, set rsp_status=0, rsp_valid=1 next cycle.
  - Counter reaches TIMEOUT-1 with no out_valid: rsp_status=1, rsp_err/complete/info=0.
  - out_valid and timeout in the same cycle: out_valid wins.
- out_valid during SEND/GAP/IDLE/RESP is ignored and not captured.
- RESP: rsp_* are held stable while rsp_valid && !rsp_ready. On the handshake edge go to IDLE, clear rsp_valid and rsp_* to 0, and raise cmd_ready.
  - The earliest next act_valid is therefore 2 cycles after the response handshake. This guarantees at least 1 idle cycle after out_valid.
- Gap counter is 3 bits and saturates at the target. The wait counter is sized clog2(TIMEOUT)+1 bits with no wrap.

Optional Feature:
- Macro FD_TX_RAND_GAP_EN.
- Defined: each inter-field gap is drawn from an 8-bit Fibonacci LFSR (taps 8,6,5,4, seeded LFSR_SEED on rst, advanced once per strobe). Gap = (lfsr[2:0] mod 5)+1, giving 1..5 cycles. The GAP parameter is ignored.
- Undefined: every gap equals GAP, and no LFSR logic exists.

Test Plan:
- Take, GAP=1, id_en=1, id=8'h05, ctm_info=16'hC423 -> act_valid T+1 with D=48'h1; id_valid T+3 with D=48'h05; cus_valid T+5 with D=48'hC423; no other strobes.
- Order, res_en=0, food=6'h12 -> act_valid T+1 (D=4); food_valid T+3 (D=48'h12); res_valid never asserted.
- Cancel, res=8'h22, food=6'h31, id=8'h07, GAP=3 -> strobes act, res, food, id at T+1, T+5, T+9, T+13 with D=8, 22, 31, 07 (hex).
- Deliver, then out_valid 6 cycles after id strobe with err_msg=4'hA, complete=0, out_info=64'h0; rsp_ready low 3 cycles -> rsp_status=0, rsp_err=4'hA held for 3 cycles; cmd_ready rises after the handshake.
- TIMEOUT=16, no out_valid -> rsp_valid asserted 17 cycles after the last strobe, rsp_status=1. Also: cmd_act=4'd3 -> rsp_status=2 at T+1, no strobes.
- rst pulsed during GAP of a Cancel -> next cycle all strobes 0, D=0, cmd_ready=1. A new Take then runs cleanly from T+1.
